// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared constants, state encoding and slot builder for the serial register bus host
package bus_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam int         SLOT_BITS = 13;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_DONE
  } state_t;

  // One downlink slot, first bit in the MSB: gap, start, flag, d7..d0, two trailing zeros
  function automatic logic [SLOT_BITS-1:0] build_slot(input logic flag, input logic [7:0] b);
    return {1'b0, 1'b1, flag, b, 2'b00};
  endfunction

endpackage

// File: rtl/bus_byte_rx.sv
// rtl/bus_byte_rx.sv - uplink deserializer: start hunt, flag plus 8 data bits, two stop bits
module bus_byte_rx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       rx,
  output logic       start,
  output logic       byte_valid,
  output logic       flag,
  output logic [7:0] data,
  output logic       frame_err
);

  logic       busy;
  logic [3:0] cnt;
  logic [8:0] sh;
  logic       stop_bad;

  // A start bit is any 1 seen while hunting; the host uses this to restart its timeout
  assign start = en & ~busy & rx;

  // Frame shifter: bits 0..8 are flag and data, 9..10 the stop bits; disabling drops any partial frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      cnt        <= 4'd0;
      sh         <= 9'd0;
      stop_bad   <= 1'b0;
      byte_valid <= 1'b0;
      flag       <= 1'b0;
      data       <= 8'd0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (!en) begin
        busy <= 1'b0;
        cnt  <= 4'd0;
      end else if (!busy) begin
        if (rx) begin
          busy     <= 1'b1;
          cnt      <= 4'd0;
          stop_bad <= 1'b0;
        end
      end else begin
        cnt <= cnt + 4'd1;
        if (cnt < 4'd9) begin
          sh <= {sh[7:0], rx};
        end else begin
          stop_bad <= stop_bad | rx;
        end
        if (cnt == 4'd10) begin
          busy       <= 1'b0;
          byte_valid <= 1'b1;
          frame_err  <= stop_bad | rx;
          flag       <= sh[8];
          data       <= sh[7:0];
        end
      end
    end
  end

endmodule

// File: rtl/bus_host.sv
// rtl/bus_host.sv - host master: serializes one register request and parses the slave reply
module bus_host #(
  parameter int TIMEOUT = 1024,
  parameter int TOW     = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wrdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [15:0] rsp_rddata,
  output logic        tx,
  input  logic        rx
);
  import bus_pkg::*;

  state_t          state;
  logic [64:0]     msg;
  logic [64:0]     tx_sh;
  logic [6:0]      bit_cnt;
  logic [TOW-1:0]  tcnt;
  logic            op_wr;
  logic [15:0]     rd_sh;
  logic [1:0]      dcnt;
  logic            cmd_ok;

  logic            rx_en;
  logic            rx_start;
  logic            rx_valid;
  logic            rx_flag;
  logic [7:0]      rx_data;
  logic            rx_ferr;

  assign rx_en = (state == ST_WAIT);

  // Whole message, first bit in the MSB; reads occupy the top 39 bits
  always_comb begin
    msg = 65'd0;
    if (req_wr) begin
      msg = {build_slot(1'b0, req_wrdata[15:8]), build_slot(1'b0, req_wrdata[7:0]),
             build_slot(1'b0, req_addr[15:8]),   build_slot(1'b0, req_addr[7:0]),
             build_slot(1'b1, CMD_WRITE)};
    end else begin
      msg = {build_slot(1'b0, req_addr[15:8]), build_slot(1'b0, req_addr[7:0]),
             build_slot(1'b1, CMD_READ), 26'd0};
    end
  end

  // Reply is acceptable only with the matching command and the expected data byte count
  assign cmd_ok = op_wr ? (rx_data == CMD_WRITE && dcnt == 2'd0)
                        : (rx_data == CMD_READ  && dcnt == 2'd2);

  bus_byte_rx u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (rx_en),
    .rx         (rx),
    .start      (rx_start),
    .byte_valid (rx_valid),
    .flag       (rx_flag),
    .data       (rx_data),
    .frame_err  (rx_ferr)
  );

  // Request/transmit/reply FSM with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rddata <= 16'd0;
      tx         <= 1'b0;
      tx_sh      <= 65'd0;
      bit_cnt    <= 7'd0;
      tcnt       <= '0;
      op_wr      <= 1'b0;
      rd_sh      <= 16'd0;
      dcnt       <= 2'd0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            tx        <= msg[64];
            tx_sh     <= {msg[63:0], 1'b0};
            bit_cnt   <= req_wr ? 7'd64 : 7'd38;
            op_wr     <= req_wr;
            req_ready <= 1'b0;
            state     <= ST_SEND;
          end else begin
            req_ready <= 1'b1;
          end
        end
        ST_SEND: begin
          if (bit_cnt != 7'd0) begin
            tx      <= tx_sh[64];
            tx_sh   <= {tx_sh[63:0], 1'b0};
            bit_cnt <= bit_cnt - 7'd1;
          end else begin
            tx    <= 1'b0;
            tcnt  <= '0;
            dcnt  <= 2'd0;
            rd_sh <= 16'd0;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (rx_start) begin
            tcnt <= '0;
          end else begin
            tcnt <= tcnt + TOW'(1);
          end
          if (rx_valid && rx_ferr) begin
            rsp_valid  <= 1'b1;
            rsp_err    <= 1'b1;
            rsp_rddata <= 16'd0;
            state      <= ST_DONE;
          end else if (rx_valid && !rx_flag) begin
            rd_sh <= {rd_sh[7:0], rx_data};
            if (dcnt != 2'd3) begin
              dcnt <= dcnt + 2'd1;
            end
          end else if (rx_valid) begin
            rsp_valid  <= 1'b1;
            rsp_err    <= ~cmd_ok;
            rsp_rddata <= (cmd_ok && !op_wr) ? rd_sh : 16'd0;
            state      <= ST_DONE;
          end else if (tcnt == TOW'(TIMEOUT)) begin
            rsp_valid  <= 1'b1;
            rsp_err    <= 1'b1;
            rsp_rddata <= 16'd0;
            state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          rsp_err    <= 1'b0;
          rsp_rddata <= 16'd0;
          req_ready  <= 1'b1;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
